// File: rtl/count_checker.sv
// Integrity monitor for a free-running counter: checks each enabled sample is
// the previous sample +1 (mod 2^WIDTH), tracks lock, and keeps error/wrap stats.
module count_checker #(
  parameter int WIDTH    = 4,
  parameter int SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [7:0]       wrap_count,
  output logic [WIDTH-1:0] last_q,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } state_t;

  localparam logic [3:0] SYNC_LEN_C = 4'(SYNC_LEN);

  state_t           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic             err_pulse_q, err_pulse_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [7:0]       wrap_count_q, wrap_count_d;
  logic [WIDTH-1:0] last_q_q, last_q_d;

  logic [WIDTH-1:0] expected_next;
  logic [3:0]       good_inc;
  logic             match;
  logic             wrap_evt;

  assign expected_next = last_q_q + WIDTH'(1);
  assign match         = (q_in == expected_next);
  assign wrap_evt      = (&last_q_q) && (q_in == '0);
  assign good_inc      = good_cnt_q + 4'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      good_cnt_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      last_q_q     <= '0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      last_q_q     <= last_q_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    err_pulse_d  = 1'b0;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q;
    last_q_d     = last_q_q;

    if (en) begin
      // Every sample, good or bad, becomes the reference for the next one.
      last_q_d = q_in;
      unique case (state_q)
        IDLE: begin
          state_d    = SYNC;
          good_cnt_d = '0;
        end
        SYNC, LOST: begin
          if (match) begin
            good_cnt_d = good_inc;
            if (good_inc == SYNC_LEN_C) state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            if (wrap_evt) wrap_count_d = wrap_count_q + 8'd1;
          end else begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            good_cnt_d  = '0;
            state_d     = LOST;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A clear on the same edge as a counted event wins; the event is dropped.
    if (clear) begin
      err_count_d  = '0;
      wrap_count_d = '0;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign last_q     = last_q_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_count_checker.sv
// Bench for count_checker: directed counter sequences, a small reference model
// feeding an expected queue, and a monitor that checks each sampled edge.
module tb_count_checker;

  localparam int WIDTH    = 4;
  localparam int SYNC_LEN = 2;

  // Handshake: each driven sample pushes one expected entry; the monitor pops
  // one entry 1 ns after the rising edge that consumed that sample.

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [WIDTH-1:0] q_in;
  logic             clear;
  logic             locked;
  logic             err_pulse;
  logic [7:0]       err_count;
  logic [7:0]       wrap_count;
  logic [WIDTH-1:0] last_q;
  logic [1:0]       state_dbg;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .q_in       (q_in),
    .clear      (clear),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .last_q     (last_q),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  logic [23:0] mon_exp;
  int checks = 0;
  int errors = 0;

  // Reference model: states 0 IDLE, 1 SYNC, 2 LOCKED, 3 LOST
  int m_state, m_good, m_last, m_err, m_wrap, m_pulse;
  int cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_good = 0; m_last = 0; m_err = 0; m_wrap = 0; m_pulse = 0;
  endtask

  task automatic model_step(input logic e, input int q, input logic c);
    bit matched;
    m_pulse = 0;
    if (e) begin
      matched = (q == ((m_last + 1) % 16));
      case (m_state)
        0: begin m_state = 1; m_good = 0; end
        1, 3: begin
          if (matched) begin
            m_good++;
            if (m_good == SYNC_LEN) m_state = 2;
          end else m_good = 0;
        end
        2: begin
          if (matched) begin
            if (m_last == 15 && q == 0) m_wrap = (m_wrap + 1) % 256;
          end else begin
            m_pulse = 1;
            if (m_err < 255) m_err++;
            m_good = 0;
            m_state = 3;
          end
        end
        default: m_state = 0;
      endcase
      m_last = q;
    end
    if (c) begin m_err = 0; m_wrap = 0; end
  endtask

  function automatic logic [23:0] model_pack();
    logic [23:0] v;
    v[23:22] = 2'(m_state);
    v[21]    = (m_state == 2);
    v[20]    = m_pulse[0];
    v[19:12] = 8'(m_err);
    v[11:4]  = 8'(m_wrap);
    v[3:0]   = 4'(m_last);
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic e, input int q, input logic c);
    @(negedge clk);
    en    = e;
    q_in  = 4'(q);
    clear = c;
    model_step(e, q % 16, c);
    exp_q.push_back(model_pack());
    if (e) cur = q % 16;
  endtask

  task automatic count_on(input int n);
    for (int i = 0; i < n; i++) step(1'b1, (cur + 1) % 16, 1'b0);
  endtask

  task automatic bad(input logic c);
    step(1'b1, (cur + 5) % 16, c);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      check("state",      32'(state_dbg),  32'(mon_exp[23:22]));
      check("locked",     32'(locked),     32'(mon_exp[21]));
      check("err_pulse",  32'(err_pulse),  32'(mon_exp[20]));
      check("err_count",  32'(err_count),  32'(mon_exp[19:12]));
      check("wrap_count", 32'(wrap_count), 32'(mon_exp[11:4]));
      check("last_q",     32'(last_q),     32'(mon_exp[3:0]));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; en = 1'b0; q_in = '0; clear = 1'b0; cur = 0;
    model_reset();
    #15;
    check("rst_locked", 32'(locked), 0);
    check("rst_pulse",  32'(err_pulse), 0);
    check("rst_err",    32'(err_count), 0);
    check("rst_wrap",   32'(wrap_count), 0);
    check("rst_last",   32'(last_q), 0);
    check("rst_state",  32'(state_dbg), 0);
    @(negedge clk);
    reset = 1'b0;

    // Lock acquisition: 0,1,2,3
    step(1'b1, 0, 1'b0);
    settle();
    check("acq_after0_locked", 32'(locked), 0);
    step(1'b1, 1, 1'b0);
    settle();
    check("acq_after1_locked", 32'(locked), 0);
    step(1'b1, 2, 1'b0);
    settle();
    check("acq_after2_locked", 32'(locked), 1);
    step(1'b1, 3, 1'b0);
    settle();
    check("acq_last_q", 32'(last_q), 3);

    // Wrap: 4..15, 0 -> first roll-over
    count_on(12);
    settle();
    check("wrap_before", 32'(wrap_count), 0);
    count_on(1);
    settle();
    check("wrap_first", 32'(wrap_count), 1);
    check("wrap_no_pulse", 32'(err_pulse), 0);
    count_on(256);
    settle();
    check("wrap_17", 32'(wrap_count), 17);

    // Error and re-lock: last_q=3, then 9, 10, 11
    count_on(3);
    step(1'b1, 9, 1'b0);
    settle();
    check("err_pulse_hi", 32'(err_pulse), 1);
    check("err_count_1", 32'(err_count), 1);
    check("err_unlocked", 32'(locked), 0);
    step(1'b1, 10, 1'b0);
    settle();
    check("err_pulse_once", 32'(err_pulse), 0);
    step(1'b1, 11, 1'b0);
    settle();
    check("relocked", 32'(locked), 1);
    bad(1'b0);
    bad(1'b0);
    settle();
    check("lost_no_pulse", 32'(err_pulse), 0);
    check("lost_no_count", 32'(err_count), 2);

    // en gating: lock, hold 5 cycles with the counter running, resume skipped
    count_on(2);
    for (int i = 1; i <= 5; i++) step(1'b0, (cur + i) % 16, 1'b0);
    settle();
    check("gate_hold_last", 32'(last_q), 32'(cur));
    step(1'b1, (cur + 7) % 16, 1'b0);
    settle();
    check("gate_skip_pulse", 32'(err_pulse), 1);
    check("gate_skip_err", 32'(err_count), 3);

    // Saturation: 300 mismatches taken in LOCKED
    count_on(2);
    for (int i = 0; i < 300; i++) begin
      bad(1'b0);
      count_on(2);
    end
    settle();
    check("sat_255", 32'(err_count), 255);
    bad(1'b1);
    settle();
    check("clr_err", 32'(err_count), 0);
    check("clr_pulse", 32'(err_pulse), 1);
    check("clr_wrap", 32'(wrap_count), 0);

    // Build err_count=4 while locked, then async reset mid-cycle
    for (int i = 0; i < 4; i++) begin
      count_on(2);
      bad(1'b0);
    end
    count_on(2);
    settle();
    check("pre_rst_err", 32'(err_count), 4);
    check("pre_rst_locked", 32'(locked), 1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    en    = 1'b0;
    #1;
    check("arst_locked", 32'(locked), 0);
    check("arst_err", 32'(err_count), 0);
    check("arst_wrap", 32'(wrap_count), 0);
    check("arst_last", 32'(last_q), 0);
    check("arst_state", 32'(state_dbg), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 7, 1'b0);
    settle();
    check("post_rst_state", 32'(state_dbg), 1);
    check("post_rst_locked", 32'(locked), 0);

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_checker.md
# count_checker

Downstream consumer of the 4-bit free-running synchronous counter. Samples the counter value each enabled cycle, checks that it advances by exactly +1 modulo 2^WIDTH, acquires and tracks lock through a small state machine, and keeps saturating error and wrapping roll-over statistics. It is the integrity monitor placed after every counter instance in the digital-circuits test designs.

## Interface
- WIDTH, 4, width of the monitored count.
- SYNC_LEN, 2, consecutive correct increments required to declare lock (1..15).
- clk  input  1  rising-edge clock, same clock as the counter.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  sample qualifier; q_in is evaluated only on edges where en=1.
- q_in  input  WIDTH  counter value under check.
- clear  input  1  synchronous clear of err_count and wrap_count only.
- locked  output  1  high while state is LOCKED.
- err_pulse  output  1  one-cycle flag for a mismatch detected in LOCKED.
- err_count  output  8  saturating count of LOCKED mismatches.
- wrap_count  output  8  modulo-256 count of roll-overs seen in LOCKED.
- last_q  output  WIDTH  most recently sampled q_in.

## Operation
- Reset (async, active-high) values: state=IDLE, good_cnt=0, locked=0, err_pulse=0, err_count=0, wrap_count=0, last_q=0.
- Match: q_in == (last_q + 1) mod 2^WIDTH, computed at WIDTH bits (all-ones followed by 0 is a match).
- Every enabled sample loads last_q <= q_in, in every state.
- en=0: state, good_cnt, counters and last_q hold; err_pulse=0.
- States:
  - IDLE: first enabled sample -> SYNC, good_cnt=0 (no comparison; no prior value).
  - SYNC: match -> good_cnt+1; when the new good_cnt == SYNC_LEN -> LOCKED. Mismatch -> good_cnt=0, stay.
  - LOCKED: match -> stay; if last_q is all-ones and q_in is 0, wrap_count+1 (mod 256). Mismatch -> err_pulse=1 for one cycle, err_count+1 saturating at 255, good_cnt=0, -> LOST.
  - LOST: same acquisition rule as SYNC (SYNC_LEN matches -> LOCKED). A mismatch clears good_cnt, raises no err_pulse and does not increment err_count.
- The mismatching sample becomes the new reference in last_q (resynchronisation on the new value).
- clear=1: err_count and wrap_count <= 0 on that edge. Clear takes priority over a simultaneous increment (the event is not counted). err_pulse and state transitions are unaffected.
- good_cnt: 4-bit internal register, never exposed.

## Timing
- All outputs registered; no combinational input-to-output path.
- Sample taken on the rising edge; its effects are visible after that same edge (latency 1 clk from q_in stable).
- locked rises after the edge that samples the SYNC_LEN-th consecutive match. It falls after the edge that samples the mismatch, coincident with err_pulse=1.
- err_pulse lasts exactly one cycle, even if en stays high with further mismatches (they arrive in LOST).
- Reset asserted mid-cycle: outputs go to their reset values without waiting for clk. On release, the first enabled edge is treated as an IDLE sample.
- Counter driven from the same clk: q_in changes just after each edge, so each edge compares the previous and current counter output.

## Test plan
- Lock acquisition, SYNC_LEN=2: reset 20 ns, en=1, q_in 0,1,2,3 on successive edges -> locked=0 after samples 0 and 1, locked=1 after sample 2, last_q=3 after the fourth edge.
- Wrap: locked, q_in 14,15,0,1 -> wrap_count goes 0->1 after sample 0. No err_pulse. Sixteen further full cycles -> wrap_count=17.
- Error and re-lock: locked with last_q=3, inject q_in=9 then 10,11 -> err_pulse=1 for one cycle and err_count=1, locked=0. Locked=1 again after sample 11. A second bad value inside LOST raises no pulse.
- Saturation and clear: force 300 LOCKED mismatches -> err_count stops at 255. Pulse clear on the same edge as an error -> err_count=0, err_pulse=1.
- en gating: en=0 for 5 cycles while the counter runs -> no change in any output. Re-enabling with a skipped value -> one mismatch (err_pulse if LOCKED).
- Async reset mid-operation: assert reset 3 ns after an edge while locked, with err_count=4 -> all outputs 0 before the next edge. The first sample after release gives state SYNC, locked=0.
